msg_feeder: RTL
===============

// Module: msg_feeder
// PURPOSE
//  Host-side framer/collector for the BLAKE2 byte interface: accepts host words, serializes them LSB-byte-first
//  into the message-manager byte stream with start/finish framing, then gathers the returned digest bytes
//  into one W*8-bit register. Sits between the host bus and the message manager; one message in flight at a time.
// PARAMETERS
//  W           32    hash word width; digest = W bytes (W*8 bits)
//  DIN_BYTES   4     bytes per host word (s_data width = 8*DIN_BYTES)
//  TIMEOUT_CYC 1024  digest-wait watchdog limit, cycles (used only with MSG_FEEDER_TIMEOUT_EN)
// PORTS
//  clk          in   1              clock; all logic on posedge
//  rst          in   1              synchronous, active-high reset
//  s_data       in   8*DIN_BYTES    host word; byte 0 = s_data[7:0], sent first
//  s_nbytes     in   $clog2(DIN_BYTES+1)  valid bytes in word (DIN_BYTES unless s_last; 0 legal only with s_last)
//  s_last       in   1              word ends the message
//  s_valid      in   1              host word valid
//  s_ready      out  1              word accepted when s_valid & s_ready
//  data_out     out  8              message byte to manager
//  dv_out       out  1              data_out valid (never high while drdy_in low)
//  drdy_in      in   1              manager can take a byte this cycle
//  start_out    out  1              one-cycle message start pulse
//  finish_out   out  1              final-byte/finish marker
//  dg_data      in   8              returned digest byte
//  dg_dv        in   1              dg_data valid
//  dg_end       in   1              last digest byte
//  digest       out  W*8            collected digest; byte k at digest[8k +: 8]
//  digest_valid out  1              digest complete and stable
//  busy         out  1              state != IDLE and != DONE
//  err_len      out  1              sticky: dg_end count != W, or dg_dv with count already W
//  err_timeout  out  1              sticky: watchdog fired
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; digest cleared; buffer empty; counters 0. Reset mid-message aborts it, no finish sent.
//  States: IDLE -> START (first word accepted) -> SEND -> [FIN] -> WAIT -> DONE; DONE behaves as IDLE for acceptance.
//  IDLE/DONE: s_ready=1; on accept load one-word buffer, clear digest/errors/digest_valid, go START.
//  START: start_out=1 for exactly one cycle, dv_out=0; next SEND.
//  SEND: dv_out = buffer nonempty & drdy_in; each dv_out cycle pops byte, byte index increments.
//   s_ready = buffer empty & last not yet accepted (one bubble cycle per word; no combinational path from drdy_in).
//   finish_out=1 with dv_out of the final byte of the s_last word; then WAIT.
//   s_last word with s_nbytes=0 (empty message or empty tail): go FIN; finish_out=1 alone for 1 cycle, dv_out=0; then WAIT.
//  WAIT: s_ready=0; each dg_dv writes dg_data to digest[8*cnt +: 8], cnt++ (cnt width $clog2(W)+1).
//   dg_dv with cnt==W: byte dropped, err_len=1. dg_end: go DONE; err_len=1 if cnt+1 != W.
//  DONE: digest_valid=1, digest held until next accepted word.
//  dg_dv outside WAIT: ignored, no state change. Latency start_out -> first dv_out >= 1 cycle.
// CONFIGURATION
//  MSG_FEEDER_TIMEOUT_EN defined: WAIT counts idle cycles (reset on each dg_dv); at TIMEOUT_CYC -> err_timeout=1,
//   state IDLE, digest_valid=0. Undefined: WAIT indefinitely; err_timeout tied 0, no counter.
// STRUCTURE
//  Shared package bloke2_pkg: state encodings, default W, DIN_BYTES, byte-count width helper.
//  Sub-module byte_serializer: one-word buffer + byte index/pop logic, emits byte, empty, last-byte flags.
// TESTING
//  1 Empty msg: s_last=1,s_nbytes=0 -> start_out 1 cyc, then finish_out alone 1 cyc, dv_out never high.
//  2 "abc": s_data=32'h00636261,nbytes=3,last -> bytes 61,62,63; finish_out only with 63; feed 32 digest bytes 00..1F ->
//    digest=256'h1F1E..0100, digest_valid=1, err_len=0.
//  3 Backpressure: 2 words 0x03020100,0x07060504 (last), drdy_in toggling 1010.. -> bytes 00..07 in order, dv_out&~drdy_in never.
//  4 Short digest: dg_end on 31st byte -> DONE, err_len=1; next message clears err_len and digest_valid.
//  5 rst mid-SEND after 2 bytes -> next cycle all outputs 0, IDLE; fresh message framed normally.
//  6 MSG_FEEDER_TIMEOUT_EN, TIMEOUT_CYC=16, no dg_dv -> err_timeout at 16 idle cycles, IDLE, s_ready=1.

Source files
------------

// File: rtl/bloke2_pkg.sv
// Shared definitions for the BLAKE2 host-side byte framer: FSM state encoding,
// default widths and the byte-count width helper.
package bloke2_pkg;

  localparam int W_DEF         = 32;
  localparam int DIN_BYTES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_FIN   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Width needed to hold a byte count from 0 to n inclusive.
  function automatic int nb_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// One-word holding buffer that hands out its bytes LSB first; flags when the
// buffer is drained and when the current byte closes the message.
module byte_serializer
  import bloke2_pkg::*;
#(
  parameter int DIN_BYTES = DIN_BYTES_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [8*DIN_BYTES-1:0]           load_data,
  input  logic [$clog2(DIN_BYTES+1)-1:0]   load_nbytes,
  input  logic                             load_last,
  input  logic                             pop,
  output logic [7:0]                       byte_out,
  output logic                             empty,
  output logic                             last_byte
);

  localparam int NBW = nb_width(DIN_BYTES);

  logic [8*DIN_BYTES-1:0] data_q;
  logic [NBW-1:0]         nbytes_q;
  logic [NBW-1:0]         idx_q;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      nbytes_q <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else if (load) begin
      data_q   <= load_data;
      nbytes_q <= load_nbytes;
      idx_q    <= '0;
      last_q   <= load_last;
    end else if (pop && !empty) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign empty     = (idx_q == nbytes_q);
  assign byte_out  = data_q[8*idx_q +: 8];
  assign last_byte = last_q && !empty && ((idx_q + 1'b1) == nbytes_q);

endmodule

// File: rtl/msg_feeder.sv
// Frames host words into a start/byte/finish stream and collects the returned
// digest bytes. Optional digest-wait watchdog: define MSG_FEEDER_TIMEOUT_EN.
module msg_feeder
  import bloke2_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter int DIN_BYTES   = DIN_BYTES_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [8*DIN_BYTES-1:0]         s_data,
  input  logic [$clog2(DIN_BYTES+1)-1:0] s_nbytes,
  input  logic                           s_last,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [7:0]                     data_out,
  output logic                           dv_out,
  input  logic                           drdy_in,
  output logic                           start_out,
  output logic                           finish_out,
  input  logic [7:0]                     dg_data,
  input  logic                           dg_dv,
  input  logic                           dg_end,
  output logic [W*8-1:0]                 digest,
  output logic                           digest_valid,
  output logic                           busy,
  output logic                           err_len,
  output logic                           err_timeout
);

  localparam int             CW    = $clog2(W) + 1;
  localparam logic [CW-1:0]  W_CNT = CW'(W);

  state_t        state;
  logic          last_acc;
  logic [CW-1:0] cnt;
  logic          accept, idle_like;
  logic          ser_empty, ser_last_byte;
  logic [7:0]    ser_byte;

  assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
  // s_ready depends only on registered state, never on drdy_in.
  assign s_ready    = !rst && (idle_like || (state == ST_SEND && ser_empty && !last_acc));
  assign accept     = s_valid && s_ready;
  assign dv_out     = (state == ST_SEND) && !ser_empty && drdy_in;
  assign data_out   = dv_out ? ser_byte : 8'h00;
  assign start_out  = (state == ST_START);
  assign finish_out = (state == ST_FIN) || (dv_out && ser_last_byte);
  assign busy       = !idle_like;

  byte_serializer #(.DIN_BYTES(DIN_BYTES)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .load_data   (s_data),
    .load_nbytes (s_nbytes),
    .load_last   (s_last),
    .pop         (dv_out),
    .byte_out    (ser_byte),
    .empty       (ser_empty),
    .last_byte   (ser_last_byte)
  );

`ifdef MSG_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  // Down-counter reloads outside WAIT and on every digest byte.
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT || dg_dv) tmo_cnt <= TW'(TIMEOUT_CYC - 1);
    else if (tmo_cnt != '0)               tmo_cnt <= tmo_cnt - 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT_CYC > 0);
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_acc     <= 1'b0;
      cnt          <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      err_len      <= 1'b0;
`ifdef MSG_FEEDER_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
    end else begin
      if (accept) last_acc <= s_last;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            digest       <= '0;
            digest_valid <= 1'b0;
            err_len      <= 1'b0;
            cnt          <= '0;
`ifdef MSG_FEEDER_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
            state        <= ST_START;
          end
        end
        ST_START: state <= (ser_empty && last_acc) ? ST_FIN : ST_SEND;
        ST_SEND: begin
          if (dv_out && ser_last_byte)  state <= ST_WAIT;
          else if (ser_empty && last_acc) state <= ST_FIN;
        end
        ST_FIN: state <= ST_WAIT;
        ST_WAIT: begin
          if (dg_dv) begin
            if (cnt == W_CNT) begin
              err_len <= 1'b1;
            end else begin
              digest[8*cnt +: 8] <= dg_data;
              cnt                <= cnt + 1'b1;
            end
            if (dg_end) begin
              state        <= ST_DONE;
              digest_valid <= 1'b1;
              if ((cnt + 1'b1) != W_CNT) err_len <= 1'b1;
            end
          end
`ifdef MSG_FEEDER_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            err_timeout  <= 1'b1;
            digest_valid <= 1'b0;
            state        <= ST_IDLE;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
